parity_frame_checker: RTL and testbench
=======================================

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning number of data bits per frame; legal range 1..32.
REQ-002 Parameter PARITY_ODD, default 0, meaning 0 = even parity expected, 1 = odd parity expected.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port x  input  1  serial bit from upstream parity generator stage; data bits LSB first, then one parity bit.
REQ-006 Port x_valid  input  1  x is sampled only on cycles where x_valid=1.
REQ-007 Port sof  input  1  start of frame; qualifies the current x as data bit 0; ignored when x_valid=0.
REQ-008 Port data  output  DATA_BITS  last completed frame payload, bit i = i-th received data bit.
REQ-009 Port done  output  1  one-cycle pulse, frame complete.
REQ-010 Port err  output  1  parity mismatch flag, meaningful only while done=1, else 0.

Function
REQ-011 FSM SHALL have states IDLE, DATA, PAR.
REQ-012 IDLE: on x_valid&sof, SHALL store x as bit 0, init running parity to x, count=1, then go to DATA (PAR if DATA_BITS=1); all other inputs ignored.
REQ-013 DATA: on x_valid&!sof, SHALL store x at bit index count, XOR x into running parity, increment count; after bit DATA_BITS-1 is stored, go to PAR.
REQ-014 PAR: on x_valid&!sof, SHALL compare x against expected bit (running parity XOR PARITY_ODD), go to IDLE.
REQ-015 done SHALL assert exactly one cycle, the cycle after the parity bit is sampled (latency 1 from parity sample edge).
REQ-016 err SHALL equal 1 with done iff parity bit differs from expected; err=0 whenever done=0.
REQ-017 data SHALL update only together with done and hold stable until the next done; partial frames never visible on data.
REQ-018 x_valid=0 in any state SHALL hold state, count, parity, and shift contents unchanged (gaps of any length allowed).
REQ-019 sof with x_valid in DATA or PAR SHALL abort the current frame (no done), and restart as in REQ-012 with the current x as bit 0.
REQ-020 count SHALL be $clog2(DATA_BITS+1) bits wide and never wrap; it resets to 0 on every return to IDLE.
REQ-021 Back-to-back frames SHALL be supported: sof on the cycle immediately after the parity bit is accepted.

Reset
REQ-022 rst=1 at a clock edge SHALL force state IDLE, count=0, running parity=0, data=0, done=0, err=0.
REQ-023 rst asserted mid-frame SHALL discard the partial frame with no done pulse; rst has priority over all inputs.
REQ-024 After rst deasserts, the first frame SHALL be accepted on the first x_valid&sof cycle.

Structure
REQ-025 Shared package parity_pkg SHALL hold the state enum (IDLE, DATA, PAR) and the EVEN/ODD parity constants, shared with the generator stage.
REQ-026 Running parity SHALL live in one sub-module parity_acc (clear, enable, bit in, parity out), one instance.
REQ-027 All outputs SHALL be driven from registers; no combinational path from inputs to outputs.

Verification
REQ-028 DATA_BITS=8, even; sof + bits 1,0,1,0,0,1,0,1 then parity 0, contiguous -> done one cycle after parity, data=0xA5, err=0.
REQ-029 Same frame with parity bit 1 -> done=1, data=0xA5, err=1.
REQ-030 Frame 0x3C (parity 0) with random x_valid gaps of 0-5 cycles -> data=0x3C, err=0, exactly one done.
REQ-031 sof after 4 bits of a frame, then full frame 0x0F with parity 0 -> single done, data=0x0F, err=0, no done for aborted frame.
REQ-032 rst pulsed after 6 data bits, then full frame 0xFF parity 0 -> no done during reset, next done data=0xFF, err=0.
REQ-033 PARITY_ODD=1; frame 0x01 parity 0, back-to-back frame 0x03 parity 1 -> done twice, err=0 then data 0x03 err=0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator / checker pair: FSM state
// encoding, parity sense constants and the expected-parity helper.
package parity_pkg;

  // Checker FSM states: waiting for sof, collecting data bits, awaiting parity.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    PAR  = 2'b10
  } state_t;

  // Parity sense: value XORed onto the running data parity.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit the upstream generator must have sent for a given data parity.
  function automatic logic expected_parity(input logic running, input logic sense);
    return running ^ sense;
  endfunction

endpackage

// File: rtl/parity_acc.sv
// Running parity accumulator. Clear has priority over plain accumulation;
// clear together with enable loads the incoming bit as the new parity, so a
// frame start needs only a single cycle.
module parity_acc (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_bit,
  output logic o_parity
);

  logic r_par;

  // Parity register: reset, clear/load, XOR-accumulate or hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_par <= 1'b0;
    end else if (i_clear) begin
      r_par <= i_en ? i_bit : 1'b0;
    end else if (i_en) begin
      r_par <= r_par ^ i_bit;
    end else begin
      r_par <= r_par;
    end
  end

  assign o_parity = r_par;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial parity frame checker. Collects DATA_BITS bits LSB first after a
// start-of-frame, then checks the trailing parity bit. Every output comes
// from a register; a completed frame is announced with a one-cycle done
// pulse carrying the payload and the parity error flag.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 sof,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 err
);

  localparam int                CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_BITS - 1);
  localparam logic              SENSE    = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  // With a single data bit the frame goes straight from sof to the parity bit.
  localparam state_t            START_ST = (DATA_BITS == 1) ? PAR : DATA;

  state_t               r_state;
  logic [CNT_W-1:0]     r_count;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_err;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 w_done_nxt;
  logic                 w_err_nxt;
  logic                 w_acc_clr;
  logic                 w_acc_en;
  logic                 w_parity;
  logic                 w_start;
  logic                 w_take;

  // A valid sof always (re)starts a frame; a valid non-sof bit advances it.
  assign w_start = x_valid & sof;
  assign w_take  = x_valid & ~sof;

  parity_acc u_parity_acc (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (w_acc_clr),
    .i_en     (w_acc_en),
    .i_bit    (x),
    .o_parity (w_parity)
  );

  // Next-state, datapath and output decode for the frame FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;

    if (w_start) begin
      // Start or abort-and-restart: current x is data bit 0.
      w_state_nxt = START_ST;
      w_count_nxt = CNT_W'(1);
      w_shift_nxt = DATA_BITS'(x);
      w_acc_clr   = 1'b1;
      w_acc_en    = 1'b1;
    end else if (w_take) begin
      case (r_state)
        IDLE: begin
          // Stray bits outside a frame are dropped.
          w_state_nxt = IDLE;
        end
        DATA: begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (r_count == CNT_W'(i)) begin
              w_shift_nxt[i] = x;
            end else begin
              w_shift_nxt[i] = r_shift[i];
            end
          end
          w_count_nxt = r_count + CNT_W'(1);
          w_acc_en    = 1'b1;
          if (r_count == LAST_IDX) begin
            w_state_nxt = PAR;
          end else begin
            w_state_nxt = DATA;
          end
        end
        PAR: begin
          // Parity bit: publish payload and verdict, return to idle.
          w_done_nxt  = 1'b1;
          w_err_nxt   = x ^ expected_parity(w_parity, SENSE);
          w_data_nxt  = r_shift;
          w_state_nxt = IDLE;
          w_count_nxt = '0;
          w_acc_clr   = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
          w_acc_clr   = 1'b1;
        end
      endcase
    end else begin
      // No valid bit this cycle: everything holds (defaults above).
      w_state_nxt = r_state;
    end
  end

  // State, datapath and registered outputs; rst overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign data = r_data;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: an even and an odd instance share the same
// stimulus; a frame-level reference model predicts both every cycle, a small
// vector table pins down the basic frame, and hand sequences cover gaps,
// aborts, reset and back-to-back frames.
module tb_parity_frame_checker;

  localparam int NB = 8;

  logic          clk;
  logic          rst;
  logic          x;
  logic          x_valid;
  logic          sof;
  logic [NB-1:0] data_e;
  logic          done_e;
  logic          err_e;
  logic [NB-1:0] data_o;
  logic          done_o;
  logic          err_o;

  int n_cmp;
  int n_fail;
  int n_done_e;
  int n_done_o;

  // Reference model state: bits of the frame in progress.
  int            m_bits[$];
  bit            m_in;
  logic [NB-1:0] m_data;
  logic          m_done;
  logic          m_err_e;
  logic          m_err_o;

  typedef struct {
    logic          r;
    logic          v;
    logic          s;
    logic          b;
    logic          ed;
    logic          ee;
    logic [NB-1:0] edata;
  } vec_t;

  vec_t tbl[$];

  parity_frame_checker #(.DATA_BITS(NB), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sof(sof),
    .data(data_e), .done(done_e), .err(err_e)
  );

  parity_frame_checker #(.DATA_BITS(NB), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sof(sof),
    .data(data_o), .done(done_o), .err(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [NB+1:0] act, input logic [NB+1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: done/err/data got %b/%b/%h required %b/%b/%h", name,
               act[NB+1], act[NB], act[NB-1:0], exp[NB+1], exp[NB], exp[NB-1:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Frame-level behaviour: sof starts a fresh bit list, NB bits then parity.
  task automatic model_update(input logic r, input logic v, input logic s, input logic b);
    int ones;
    logic [NB-1:0] val;
    m_done  = 1'b0;
    m_err_e = 1'b0;
    m_err_o = 1'b0;
    if (r) begin
      m_bits.delete();
      m_in   = 1'b0;
      m_data = '0;
    end else if (v) begin
      if (s) begin
        m_bits.delete();
        m_bits.push_back(int'(b));
        m_in = 1'b1;
      end else if (m_in) begin
        if (m_bits.size() < NB) begin
          m_bits.push_back(int'(b));
        end else begin
          ones = 0;
          val  = '0;
          for (int i = 0; i < NB; i++) begin
            ones += m_bits[i];
            if (m_bits[i] != 0) val[i] = 1'b1;
          end
          m_data  = val;
          m_done  = 1'b1;
          m_err_e = (int'(b) != (ones % 2));
          m_err_o = (int'(b) != ((ones + 1) % 2));
          m_bits.delete();
          m_in = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive, let the edge happen, update model, compare on negedge.
  task automatic step(input logic r, input logic v, input logic s, input logic b);
    rst     = r;
    x_valid = v;
    sof     = s;
    x       = b;
    @(posedge clk);
    model_update(r, v, s, b);
    @(negedge clk);
    check("model_even", {done_e, err_e, data_e}, {m_done, m_err_e, m_data});
    check("model_odd",  {done_o, err_o, data_o}, {m_done, m_err_o, m_data});
    if (done_e === 1'b1) n_done_e++;
    if (done_o === 1'b1) n_done_o++;
  endtask

  // Full frame with optional idle gaps (sof/x randomised while not valid).
  task automatic send_frame(input logic [NB-1:0] d, input logic p, input int gap_max);
    int gaps;
    logic bv;
    for (int i = 0; i <= NB; i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gaps) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bv = (i < NB) ? d[i] : p;
      step(1'b0, 1'b1, (i == 0), bv);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic s, input logic b,
                     input logic ed, input logic ee, input logic [NB-1:0] edata);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.b = b; t.ed = ed; t.ee = ee; t.edata = edata;
    tbl.push_back(t);
  endtask

  initial begin
    logic [NB-1:0] a5;
    n_cmp = 0; n_fail = 0; n_done_e = 0; n_done_o = 0;
    m_in = 1'b0; m_data = '0; m_done = 1'b0; m_err_e = 1'b0; m_err_o = 1'b0;
    rst = 1'b1; x = 1'b0; x_valid = 1'b0; sof = 1'b0;
    a5 = 8'hA5;

    // Vector table: reset, 0xA5 with good parity, then 0xA5 with bad parity
    // including an ignored gap cycle carrying sof.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < NB; i++) add(1'b0, 1'b1, (i == 0), a5[i], 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    for (int i = 0; i < NB; i++) begin
      add(1'b0, 1'b1, (i == 0), a5[i], 1'b0, 1'b0, 8'hA5);
      if (i == 3) add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    end
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].r, tbl[k].v, tbl[k].s, tbl[k].b);
      check($sformatf("tbl[%0d]", k), {done_e, err_e, data_e}, {tbl[k].ed, tbl[k].ee, tbl[k].edata});
    end

    // 0x3C with random gaps: exactly one done.
    n_done_e = 0;
    send_frame(8'h3C, 1'b0, 5);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_int("gap_done_count", n_done_e, 1);
    check("gap_frame", {1'b0, err_e, data_e}, {1'b0, 1'b0, 8'h3C});

    // Abort after 4 bits, then full 0x0F.
    n_done_e = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i == 0), 1'($urandom_range(0, 1)));
    send_frame(8'h0F, 1'b0, 0);
    check("abort_frame", {done_e, err_e, data_e}, {1'b1, 1'b0, 8'h0F});
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_int("abort_done_count", n_done_e, 1);

    // Reset after 6 bits (with a valid sof present: reset wins), then 0xFF.
    n_done_e = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, (i == 0), 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_clears", {done_e, err_e, data_e}, {1'b0, 1'b0, 8'h00});
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_int("rst_no_done", n_done_e, 0);
    send_frame(8'hFF, 1'b0, 0);
    check("post_rst_frame", {done_e, err_e, data_e}, {1'b1, 1'b0, 8'hFF});

    // Odd instance: 0x01 parity 0 then back-to-back 0x03 parity 1.
    n_done_o = 0;
    send_frame(8'h01, 1'b0, 0);
    check("odd_frame1", {done_o, err_o, data_o}, {1'b1, 1'b0, 8'h01});
    send_frame(8'h03, 1'b1, 0);
    check("odd_frame2", {done_o, err_o, data_o}, {1'b1, 1'b0, 8'h03});
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_int("odd_done_count", n_done_o, 2);

    // Random whole frames with gaps and random parity.
    for (int f = 0; f < 30; f++) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 3);
    end

    // Fully random cycle stream: aborts, stray bits, occasional reset.
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
